// File: rtl/opl3_op_sequencer.sv
// rtl/opl3_op_sequencer.sv - per-sample operator slot scheduler with register-port arbitration
//
// Purpose:
//   Each sample_clk_en pulse starts a frame that walks every (bank, operator)
//   slot, one slot per clk, bank 0 first. The slot index drives the register
//   file read and phase-increment pipeline; a tag delayed by PIPELINE_DELAY
//   cycles marks which slot the pipeline output belongs to. While no frame is
//   running, the shared register-file port is granted to host config writes.
//
// Ports:
//   clk            system clock
//   reset_n        asynchronous active-low reset (released synchronously inside)
//   sample_clk_en  one-cycle pulse starting a sample frame
//   cfg_req        host request for the register-file port, held until granted
//   cfg_gnt        one-cycle grant; the host write happens in that cycle
//   issue_valid    bank_num/op_num carry a live slot this cycle
//   bank_num       current slot bank (holds last value when not issuing)
//   op_num         current slot operator (holds last value when not issuing)
//   wb_valid       phase increment for wb_bank/wb_op is valid this cycle
//   wb_bank        write-back bank tag
//   wb_op          write-back operator tag
//   sample_done    pulse together with the last write-back of a frame
//   busy           frame in progress (RUN or DRAIN)
//   overrun        sticky: sample_clk_en arrived while busy

module opl3_op_sequencer #(
    parameter int NUM_BANKS      = 2,
    parameter int NUM_OPS        = 18,
    parameter int BANK_NUM_WIDTH = 1,
    parameter int OP_NUM_WIDTH   = 5,
    parameter int PIPELINE_DELAY = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      sample_clk_en,
    input  logic                      cfg_req,
    output logic                      cfg_gnt,
    output logic                      issue_valid,
    output logic [BANK_NUM_WIDTH-1:0] bank_num,
    output logic [OP_NUM_WIDTH-1:0]   op_num,
    output logic                      wb_valid,
    output logic [BANK_NUM_WIDTH-1:0] wb_bank,
    output logic [OP_NUM_WIDTH-1:0]   wb_op,
    output logic                      sample_done,
    output logic                      busy,
    output logic                      overrun
);

    localparam int TAG_W   = 1 + BANK_NUM_WIDTH + OP_NUM_WIDTH;
    localparam int DRAIN_W = (PIPELINE_DELAY > 1) ? $clog2(PIPELINE_DELAY) : 1;

    localparam logic [BANK_NUM_WIDTH-1:0] BANK_LAST  = BANK_NUM_WIDTH'(NUM_BANKS - 1);
    localparam logic [OP_NUM_WIDTH-1:0]   OP_LAST    = OP_NUM_WIDTH'(NUM_OPS - 1);
    localparam logic [DRAIN_W-1:0]        DRAIN_LAST = DRAIN_W'(PIPELINE_DELAY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    // Reset synchronizer: assertion reaches every flop at once through the
    // async clear, release is delayed two edges so all flops leave reset on
    // the same clock.
    logic [1:0] rst_sync;
    logic       rst_int_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    state_t                    state_q, state_d;
    logic [BANK_NUM_WIDTH-1:0] bank_q, bank_d;
    logic [OP_NUM_WIDTH-1:0]   op_q, op_d;
    logic [DRAIN_W-1:0]        drain_q, drain_d;
    logic                      gnt_prev_q;
    logic                      overrun_q;
    logic                      gnt;
    logic                      last_slot;
    logic [TAG_W-1:0]          tag_sr [PIPELINE_DELAY];

    assign last_slot = (bank_q == BANK_LAST) && (op_q == OP_LAST);

    // State, slot counters and drain counter.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q <= S_IDLE;
            bank_q  <= '0;
            op_q    <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            op_q    <= op_d;
            drain_q <= drain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        op_d    = op_q;
        drain_d = drain_q;
        gnt     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A frame start always beats a pending host request.
                if (sample_clk_en) begin
                    state_d = S_RUN;
                    bank_d  = '0;
                    op_d    = '0;
                end else if (cfg_req && !gnt_prev_q) begin
                    gnt = 1'b1;
                end
            end
            S_RUN: begin
                if (last_slot) begin
                    // Slot registers keep the final slot; consumers ignore
                    // them once issue_valid drops.
                    state_d = S_DRAIN;
                    drain_d = '0;
                end else if (op_q == OP_LAST) begin
                    op_d   = '0;
                    bank_d = bank_q + BANK_NUM_WIDTH'(1);
                end else begin
                    op_d = op_q + OP_NUM_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                // Wait for the last issued slot to leave the pipeline.
                if (drain_q == DRAIN_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Grant history enforces a dead cycle between grants so the host has
    // time to drop cfg_req after being served.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            gnt_prev_q <= 1'b0;
        end else begin
            gnt_prev_q <= cfg_gnt;
        end
    end

    // Overrun is sticky until reset; the offending pulse is otherwise dropped.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            overrun_q <= 1'b0;
        end else if (sample_clk_en && busy) begin
            overrun_q <= 1'b1;
        end
    end

    // Tag shift register mirrors the datapath latency so each write-back
    // carries the slot that produced it.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            for (int i = 0; i < PIPELINE_DELAY; i++) begin
                tag_sr[i] <= '0;
            end
        end else begin
            tag_sr[0] <= {issue_valid, bank_q, op_q};
            for (int i = 1; i < PIPELINE_DELAY; i++) begin
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    // Gating with rst_int_n keeps the grant low while the reset release is
    // still propagating through the synchronizer.
    assign cfg_gnt     = gnt && rst_int_n;
    assign issue_valid = (state_q == S_RUN);
    assign bank_num    = bank_q;
    assign op_num      = op_q;
    assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign overrun     = overrun_q;

    assign {wb_valid, wb_bank, wb_op} = tag_sr[PIPELINE_DELAY-1];

    assign sample_done = wb_valid && (wb_bank == BANK_LAST) && (wb_op == OP_LAST);

endmodule

// File: tb/tb_opl3_op_sequencer.sv
// tb/tb_opl3_op_sequencer.sv - scoreboard bench for opl3_op_sequencer

module tb_opl3_op_sequencer;

    localparam int NB    = 2;
    localparam int NO    = 18;
    localparam int BW    = 1;
    localparam int OW    = 5;
    localparam int PD    = 2;
    localparam int NSLOT = NB * NO;

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          sample_clk_en = 1'b0;
    logic          cfg_req = 1'b0;
    logic          cfg_gnt;
    logic          issue_valid;
    logic [BW-1:0] bank_num;
    logic [OW-1:0] op_num;
    logic          wb_valid;
    logic [BW-1:0] wb_bank;
    logic [OW-1:0] wb_op;
    logic          sample_done;
    logic          busy;
    logic          overrun;

    opl3_op_sequencer #(
        .NUM_BANKS(NB), .NUM_OPS(NO), .BANK_NUM_WIDTH(BW),
        .OP_NUM_WIDTH(OW), .PIPELINE_DELAY(PD)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sample_clk_en(sample_clk_en),
        .cfg_req(cfg_req), .cfg_gnt(cfg_gnt), .issue_valid(issue_valid),
        .bank_num(bank_num), .op_num(op_num), .wb_valid(wb_valid),
        .wb_bank(wb_bank), .wb_op(wb_op), .sample_done(sample_done),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int bank;
        int op;
        bit last;
    } ev_t;

    ev_t iq[$];
    ev_t wq[$];
    int  gq[$];
    int  busy_lo = 1;
    int  busy_hi = 0;
    int  ovr_from = -1;
    int  last_gnt = -10;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic bit m_busy(input int c);
        return (c >= busy_lo) && (c <= busy_hi);
    endfunction

    // Reference model: a frame accepted in cycle c issues slot k in cycle
    // c+1+k, writes it back PD cycles later and is busy until the last
    // write-back. Grants go to idle cycles not following a grant.
    task automatic drive(input bit sce, input bit req);
        @(negedge clk);
        sample_clk_en = sce;
        cfg_req = req;
        if (sce) begin
            if (m_busy(cyc)) begin
                if (ovr_from < 0) ovr_from = cyc + 1;
            end else begin
                for (int k = 0; k < NSLOT; k++) begin
                    ev_t e;
                    e.cyc  = cyc + 1 + k;
                    e.bank = k / NO;
                    e.op   = k % NO;
                    e.last = (k == NSLOT - 1);
                    iq.push_back(e);
                    e.cyc  = cyc + 1 + k + PD;
                    wq.push_back(e);
                end
                busy_lo = cyc + 1;
                busy_hi = cyc + NSLOT + PD;
            end
        end else if (req && !m_busy(cyc) && (last_gnt != cyc - 1)) begin
            gq.push_back(cyc);
            last_gnt = cyc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        sample_clk_en = 1'b0;
        cfg_req = 1'b0;
        iq.delete();
        wq.delete();
        gq.delete();
        busy_lo = 1;
        busy_hi = 0;
        ovr_from = -1;
        last_gnt = -10;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) drive(0, 0);
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues each cycle.
    initial begin
        forever begin
            bit  exp_i, exp_w, exp_d, exp_g;
            ev_t e;
            @(negedge clk);
            #3;
            if (!reset_n) begin
                chk("reset_outputs",
                    int'({cfg_gnt, issue_valid, bank_num, op_num, wb_valid,
                          wb_bank, wb_op, sample_done, busy, overrun}), 0);
            end
            exp_i = (iq.size() > 0) && (iq[0].cyc == cyc);
            chk("issue_valid", issue_valid, exp_i);
            if (exp_i) begin
                e = iq.pop_front();
                if (issue_valid) begin
                    chk("issue_bank", bank_num, e.bank);
                    chk("issue_op", op_num, e.op);
                end
            end
            exp_w = (wq.size() > 0) && (wq[0].cyc == cyc);
            exp_d = exp_w && wq[0].last;
            chk("wb_valid", wb_valid, exp_w);
            chk("sample_done", sample_done, exp_d);
            if (exp_w) begin
                e = wq.pop_front();
                if (wb_valid) begin
                    chk("wb_bank", wb_bank, e.bank);
                    chk("wb_op", wb_op, e.op);
                end
            end
            exp_g = (gq.size() > 0) && (gq[0] == cyc);
            chk("cfg_gnt", cfg_gnt, exp_g);
            if (exp_g) void'(gq.pop_front());
            chk("busy", busy, m_busy(cyc));
            chk("overrun", overrun, (ovr_from >= 0) && (cyc >= ovr_from));
        end
    end

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) drive(0, 0);

        // Basic frame, with a second pulse mid-frame that must only flag overrun.
        while (cyc < 9) drive(0, 0);
        drive(1, 0);
        while (cyc < 29) drive(0, 0);
        drive(1, 0);
        while (cyc < 55) drive(0, 0);

        // Held request in idle: grants separated by a dead cycle.
        repeat (6) drive(0, 1);
        drive(0, 0);
        drive(0, 0);

        // Request and frame start in the same cycle, then request held through frame.
        drive(1, 1);
        repeat (45) drive(0, 1);
        drive(0, 0);

        // Reset in the middle of a frame, then a clean frame.
        drive(1, 0);
        repeat (15) drive(0, 0);
        do_reset();
        drive(1, 0);
        repeat (45) drive(0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0);
        end
        repeat (60) drive(0, 0);

        chk("leftover_issue", iq.size(), 0);
        chk("leftover_wb", wq.size(), 0);
        chk("leftover_gnt", gq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/opl3_op_sequencer.md
Name: opl3_op_sequencer

Overview:
- Per-sample scheduler for the operator phase-increment datapath.
- On each sample_clk_en it walks every (bank, operator) slot, one slot per clk. It drives bank_num/op_num into the register-file read and phase-increment pipeline.
- It emits a write-back tag aligned with the pipeline output and signals completion.
- Between samples it arbitrates the shared register-file port for host configuration writes.

Parameters:
- NUM_BANKS, 2, number of register banks.
- NUM_OPS, 18, operators per bank.
- BANK_NUM_WIDTH, 1, width of bank index.
- OP_NUM_WIDTH, 5, width of operator index.
- PIPELINE_DELAY, 2, datapath latency in clk cycles from issued slot to valid phase increment.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- sample_clk_en  in  1  one-cycle pulse starting a sample frame.
- cfg_req  in  1  host requests the register-file port; held until granted.
- cfg_gnt  out  1  grant; one-cycle pulse, host write occurs in that cycle.
- issue_valid  out  1  bank_num/op_num are a live slot this cycle.
- bank_num  out  BANK_NUM_WIDTH  current slot bank.
- op_num  out  OP_NUM_WIDTH  current slot operator.
- wb_valid  out  1  phase increment for wb_bank/wb_op is valid this cycle.
- wb_bank  out  BANK_NUM_WIDTH  write-back bank tag.
- wb_op  out  OP_NUM_WIDTH  write-back operator tag.
- sample_done  out  1  one-cycle pulse with the last write-back of a frame.
- busy  out  1  frame in progress (RUN or DRAIN).
- overrun  out  1  sticky; sample_clk_en arrived while busy.

Behaviour:
- Reset (async assert, sync deassert internally): all outputs 0, state IDLE, counters 0, tag shift register cleared. Reset mid-frame abandons the frame with no sample_done.
- States:
  - IDLE: no slot issue.
    - sample_clk_en → RUN next cycle, bank=0, op=0. A sample_clk_en in IDLE is never lost.
    - else if cfg_req and no grant in previous cycle → cfg_gnt=1 for one cycle.
  - RUN: issue_valid=1 every cycle.
    - op increments; at op=NUM_OPS-1, op wraps to 0 and bank increments.
    - After slot (NUM_BANKS-1, NUM_OPS-1) → DRAIN.
  - DRAIN: issue_valid=0. Wait PIPELINE_DELAY cycles → IDLE.
- Slot order: bank 0 ops 0..17, then bank 1 ops 0..17. Total 36 issue cycles with defaults.
- First issue is exactly 1 cycle after the sample_clk_en pulse.
- Write-back alignment: {issue_valid, bank_num, op_num} passes through a PIPELINE_DELAY-stage shift register to form wb_valid/wb_bank/wb_op. wb_valid for slot k occurs exactly PIPELINE_DELAY cycles after its issue.
- sample_done=1 in the cycle wb_valid carries the tag (NUM_BANKS-1, NUM_OPS-1).
  - With defaults, sample_done comes 1+36+2-1 = 38 cycles after sample_clk_en.
  - busy falls the next cycle.
- bank_num/op_num hold their last value when issue_valid=0. Consumers qualify with issue_valid/wb_valid only.
- Arbitration:
  - Priority: sample_clk_en wins over cfg_req in the same cycle. No grant that cycle; the frame starts.
  - cfg_gnt is never asserted while busy.
  - Grants are spaced at least 2 cycles apart so the host can drop cfg_req.
- Overrun:
  - sample_clk_en while busy sets overrun, and the pulse is otherwise ignored.
  - overrun clears only on reset.
- sample_clk_en in the cycle the FSM returns to IDLE (first IDLE cycle) is accepted normally.

Test Plan:
- Reset, pulse sample_clk_en at cycle 10 → issue_valid cycles 11..46 with slots (0,0)..(0,17),(1,0)..(1,17); wb_valid cycles 13..48 with matching tags; sample_done at 48 only; busy 11..48.
- Assert cfg_req in IDLE → cfg_gnt single pulse next eligible cycle. Hold cfg_req → next grant no sooner than 2 cycles later.
- cfg_req held, sample_clk_en at cycle 20 → no grant during cycles 20..58; first grant at 59 or later.
- cfg_req and sample_clk_en in the same IDLE cycle → cfg_gnt=0 that cycle, frame starts next cycle.
- Second sample_clk_en at cycle 30 of a frame started at 10 → overrun=1 and stays 1; frame completes unchanged with sample_done at 48; no second frame starts.
- Deassert reset_n at cycle 25 mid-frame → all outputs 0 immediately. Release, then pulse sample_clk_en → clean frame from slot (0,0) with no stale wb_valid.
